// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32M datapath width, funct3 op codes and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] c_f3_mul    = 3'b000;
    localparam logic [2:0] c_f3_mulh   = 3'b001;
    localparam logic [2:0] c_f3_mulhsu = 3'b010;
    localparam logic [2:0] c_f3_mulhu  = 3'b011;
    localparam logic [2:0] c_f3_div    = 3'b100;
    localparam logic [2:0] c_f3_divu   = 3'b101;
    localparam logic [2:0] c_f3_rem    = 3'b110;
    localparam logic [2:0] c_f3_remu   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M multiply/divide unit, fixed 35-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write
);

    localparam logic [XLEN-1:0] c_ones    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] c_min_neg = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      c_last_it = 6'd31;

    state_t              r_state;
    state_t              w_state_next;

    logic [2:0]          r_funct3;
    logic [XLEN-1:0]     r_op_a;
    logic [XLEN-1:0]     r_op_b;
    logic [4:0]          r_rd_cap;
    logic [4:0]          r_rd_out;
    logic [XLEN-1:0]     r_result;
    logic [5:0]          r_count;

    // Shared shift register: {high, low} serves as product or {remainder, quotient}.
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_mag;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_div_zero;
    logic                r_ovf;

    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_div_trial;
    logic [2*XLEN-1:0]   w_acc_step;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_result;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_PREP;
            S_PREP:  w_state_next = S_CALC;
            S_CALC:  if (r_count == c_last_it) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand preparation
    // ------------------------------------------------------------------
    always_comb begin
        w_is_div   = r_funct3[2];
        w_a_signed = (r_funct3 == c_f3_mulh) || (r_funct3 == c_f3_mulhsu) ||
                     (r_funct3 == c_f3_div)  || (r_funct3 == c_f3_rem);
        w_b_signed = (r_funct3 == c_f3_mulh) || (r_funct3 == c_f3_div) ||
                     (r_funct3 == c_f3_rem);
        w_a_neg    = w_a_signed && r_op_a[XLEN-1];
        w_b_neg    = w_b_signed && r_op_b[XLEN-1];
        w_mag_a    = w_a_neg ? (~r_op_a + 1'b1) : r_op_a;
        w_mag_b    = w_b_neg ? (~r_op_b + 1'b1) : r_op_b;
    end

    // ------------------------------------------------------------------
    // One iteration: shift-add multiply or restoring divide
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mag};
        w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mag};
        if (w_is_div) begin
            if (w_div_trial[XLEN]) begin
                w_acc_step = {r_acc[2*XLEN-2:0], 1'b0};
            end else begin
                w_acc_step = {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end
        end else begin
            if (r_acc[0]) begin
                w_acc_step = {w_mul_sum, r_acc[XLEN-1:1]};
            end else begin
                w_acc_step = {1'b0, r_acc[2*XLEN-1:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------
    always_comb begin
        w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
        w_quo  = r_neg_q ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
        w_rem  = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
        w_fix_result = '0;
        case (r_funct3)
            c_f3_mul: begin
                w_fix_result = w_prod[XLEN-1:0];
            end
            c_f3_mulh, c_f3_mulhsu, c_f3_mulhu: begin
                w_fix_result = w_prod[2*XLEN-1:XLEN];
            end
            c_f3_div, c_f3_divu: begin
                if (r_div_zero)  w_fix_result = c_ones;
                else if (r_ovf)  w_fix_result = c_min_neg;
                else             w_fix_result = w_quo;
            end
            default: begin
                if (r_div_zero)  w_fix_result = r_op_a;
                else if (r_ovf)  w_fix_result = '0;
                else             w_fix_result = w_rem;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_funct3   <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_rd_cap   <= '0;
            r_rd_out   <= '0;
            r_result   <= '0;
            r_count    <= '0;
            r_acc      <= '0;
            r_mag      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_funct3 <= funct3;
                        r_op_a   <= op_a;
                        r_op_b   <= op_b;
                        r_rd_cap <= rd_in;
                    end
                end
                S_PREP: begin
                    r_count    <= '0;
                    r_neg_q    <= w_a_neg ^ w_b_neg;
                    r_neg_r    <= w_a_neg;
                    r_div_zero <= w_is_div && (r_op_b == '0);
                    r_ovf      <= w_is_div && !r_funct3[0] &&
                                  (r_op_a == c_min_neg) && (r_op_b == c_ones);
                    if (w_is_div) begin
                        r_mag <= w_mag_b;
                        r_acc <= {{XLEN{1'b0}}, w_mag_a};
                    end else begin
                        r_mag <= w_mag_a;
                        r_acc <= {{XLEN{1'b0}}, w_mag_b};
                    end
                end
                S_CALC: begin
                    r_acc   <= w_acc_step;
                    r_count <= r_count + 6'd1;
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                    r_rd_out <= r_rd_cap;
                    r_count  <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign rd_out    = r_rd_out;
    assign reg_write = done && (r_rd_out != 5'd0);

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        reg_write;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out),
        .reg_write (reg_write)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch at edge k, expect done exactly after edge k+34, idle after k+35.
    // If inject is set, a second start with different operands is pulsed mid-CALC.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input logic exp_rw, input bit inject);
        int early;
        early = 0;
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        funct3 = 3'b101; op_a = 32'd100; op_b = 32'd5; rd_in = 5'd9;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) early++;
            if (inject && i == 10) start = 1'b1;
            if (inject && i == 12) start = 1'b0;
        end
        chk({tag, "_no_early_done"}, early, 0);
        @(posedge clk);
        #1;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_rd_out"}, {27'd0, rd_out}, {27'd0, rd});
        chk({tag, "_reg_write"}, {31'd0, reg_write}, {31'd0, exp_rw});
        @(posedge clk);
        #1;
        chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hold"}, result, exp);
    endtask

    initial begin
        int seen_done;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mul",    3'b000, 32'd7,          32'd6,          5'd5, 32'd42,         1'b1, 1'b0);
        run_op("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000,  5'd1, 32'h4000_0000,  1'b1, 1'b0);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2, 32'hFFFF_FFFE,  1'b1, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'd2,          5'd3, 32'hFFFF_FFFF,  1'b1, 1'b0);
        run_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,          5'd4, 32'hFFFF_FFFD,  1'b1, 1'b0);
        run_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,          5'd6, 32'hFFFF_FFFF,  1'b1, 1'b0);
        run_op("divu",   3'b101, 32'd9,          32'd2,          5'd7, 32'd4,          1'b1, 1'b0);
        run_op("remu",   3'b111, 32'd9,          32'd2,          5'd8, 32'd1,          1'b1, 1'b0);
        run_op("div0",   3'b100, 32'd5,          32'd0,          5'd9, 32'hFFFF_FFFF,  1'b1, 1'b0);
        run_op("rem0",   3'b110, 32'd5,          32'd0,          5'd10, 32'd5,         1'b1, 1'b0);
        run_op("divu0",  3'b101, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000, 1'b1, 1'b0);
        run_op("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,         1'b1, 1'b0);
        run_op("inject", 3'b000, 32'd2,          32'd3,          5'd14, 32'd6,         1'b1, 1'b1);

        // Abort a divide in the middle of CALC.
        @(negedge clk);
        funct3 = 3'b100; op_a = 32'd50; op_b = 32'd3; rd_in = 5'd15; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) seen_done++;
        end
        chk("abort_no_done", seen_done, 0);

        run_op("divu_after", 3'b101, 32'd100, 32'd7, 5'd16, 32'd14, 1'b1, 1'b0);
        run_op("mul_rd0",    3'b000, 32'd3,   32'd3, 5'd0,  32'd9,  1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter: XLEN, default 32, datapath width (only 32 supported).
REQ-002 SHALL have port: clk  in  1  system clock; all state updates on posedge clk.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  request; sampled only in IDLE.
REQ-005 SHALL have port: funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: op_a  in  32  rs1 operand, driven from register-file out1.
REQ-007 SHALL have port: op_b  in  32  rs2 operand, driven from register-file out2.
REQ-008 SHALL have port: rd_in  in  5  destination register tag.
REQ-009 SHALL have port: busy  out  1  high whenever state is not IDLE.
REQ-010 SHALL have port: done  out  1  one-cycle pulse; result valid.
REQ-011 SHALL have port: result  out  32  write-back data for register-file write_data.
REQ-012 SHALL have port: rd_out  out  5  captured rd_in, for register-file rd.
REQ-013 SHALL have port: reg_write  out  1  equals done AND (rd_out != 0).

Function
REQ-014 SHALL implement FSM IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
REQ-015 In IDLE with start=1 at edge k, SHALL capture funct3, op_a, op_b, rd_in and enter PREP; start is ignored in all other states.
REQ-016 PREP (1 cycle) SHALL take operand magnitudes per signedness (MULH/DIV/REM: both signed; MULHSU: op_a signed only; others unsigned), record result sign, and detect divide-by-zero and overflow.
REQ-017 CALC SHALL run exactly 32 iterations via a 6-bit counter: shift-add multiply (64-bit product) or restoring divide (32-bit quotient and remainder); it SHALL exit to FIX at edge k+33.
REQ-018 FIX (1 cycle) SHALL apply two's-complement sign correction and select the result: MUL = product[31:0]; MULH* = product[63:32]; DIV* = quotient; REM* = remainder (remainder takes the sign of the dividend).
REQ-019 SHALL hold DONE for exactly one cycle after edge k+34, with done=1 and result/rd_out valid; it SHALL return to IDLE at edge k+35.
REQ-020 Latency SHALL be fixed at 35 cycles for all ops, including special cases.
REQ-021 Divide by zero SHALL give DIV/DIVU = 0xFFFFFFFF and REM/REMU = op_a.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give 0x80000000, and the matching REM SHALL give 0.
REQ-023 result and rd_out SHALL hold their last values until the next DONE.
REQ-024 A new start SHALL be accepted no earlier than the IDLE cycle following DONE.

Reset
REQ-025 reset=1 at any edge SHALL force IDLE, busy=0, done=0, reg_write=0, result=0, rd_out=0, counter=0.
REQ-026 Reset during PREP, CALC, FIX or DONE SHALL abort the operation without producing a done pulse.
REQ-027 Reset SHALL take priority over start on the same edge.

Structure
REQ-028 The funct3 op constants, the FSM state encoding and XLEN SHALL reside in the shared package riscv_pkg.
REQ-029 The block SHALL be a single module; no sub-module is required, and the multiply and divide datapaths SHALL share one 64-bit shift register.

Verification
REQ-030 MUL 7*6 with rd_in=5, start at edge k -> done=1 after edge k+34, result=42, rd_out=5, reg_write=1.
REQ-031 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 9/2 -> 4; REMU 9,2 -> 1.
REQ-033 DIV 5/0 -> 0xFFFFFFFF; REM 5,0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; all complete in 35 cycles.
REQ-034 start pulsed during CALC -> ignored; reset at CALC iteration 10 -> IDLE next edge, no done; a following DIVU 100/7 -> 14.
REQ-035 MUL 3*3 with rd_in=0 -> done=1, result=9, reg_write=0.
